hgcal_input_packer: RTL and testbench



---
 rtl/hgcal_input_packer.sv | 93 +++++++++
 tb/tb_hgcal_input_packer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hgcal_input_packer.sv
// hgcal_input_packer: quantizes a serial sample stream to 2-bit codes and packs each frame for layer 1 (HGCAL_PACK_STATS_EN adds frame/error counters)
module hgcal_input_packer #(
  parameter int          IN_WIDTH   = 10,
  parameter int          NUM_INPUTS = 48,
  parameter int unsigned THR1       = 64,
  parameter int unsigned THR2       = 128,
  parameter int unsigned THR3       = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_WIDTH-1:0]     s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*NUM_INPUTS-1:0] m_data,
  output logic                    m_err
`ifdef HGCAL_PACK_STATS_EN
  ,
  output logic [31:0]             stat_frames,
  output logic [31:0]             stat_errs
`endif
);
  localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  typedef enum logic [1:0] {COLLECT, DROP, HOLD} state_t;
  state_t state;
  logic [IW-1:0] index;
  logic [NUM_INPUTS-1:0][1:0] shadow, nxt;
  logic [1:0] code;
  logic acc, full;
  if (!(THR1 < THR2 && THR2 < THR3)) begin : g_thr_check
    $error("hgcal_input_packer: thresholds must satisfy THR1 < THR2 < THR3");
  end
  assign s_ready = !rst && state != HOLD;
  assign acc = s_valid && s_ready;
  assign full = index == IW'(NUM_INPUTS - 1);
  // unsigned threshold quantizer
  always_comb code = 32'(s_data) >= THR3 ? 2'd3 : 32'(s_data) >= THR2 ? 2'd2 : 32'(s_data) >= THR1 ? 2'd1 : 2'd0;
  // shadow buffer with the incoming code merged into the current slot
  always_comb begin
    nxt = shadow;
    nxt[index] = code;
  end
  // collect / drain-overlong / hold-until-handshake control
  always_ff @(posedge clk)
    if (rst) begin
      state   <= COLLECT;
      index   <= '0;
      shadow  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
    end else
      case (state)
        COLLECT:
          if (acc) begin
            shadow <= nxt;
            if (s_last) begin
              m_valid <= 1'b1;
              m_data  <= nxt;
              m_err   <= !full;
              state   <= HOLD;
            end else if (full) state <= DROP;
            else index <= index + IW'(1);
          end
        DROP:
          if (acc && s_last) begin
            m_valid <= 1'b1;
            m_data  <= shadow;
            m_err   <= 1'b1;
            state   <= HOLD;
          end
        default:
          if (m_ready) begin
            m_valid <= 1'b0;
            shadow  <= '0;
            index   <= '0;
            state   <= COLLECT;
          end
      endcase
`ifdef HGCAL_PACK_STATS_EN
  // count delivered frames and delivered errored frames
  always_ff @(posedge clk)
    if (rst) begin
      stat_frames <= '0;
      stat_errs   <= '0;
    end else if (m_valid && m_ready) begin
      stat_frames <= stat_frames + 32'd1;
      stat_errs   <= stat_errs + 32'(m_err);
    end
`endif
endmodule

// File: tb/tb_hgcal_input_packer.sv
// tb_hgcal_input_packer: directed table-driven check of the input packer with NUM_INPUTS=4
module tb_hgcal_input_packer;
  logic clk, rst, s_valid, s_ready, s_last, m_valid, m_ready, m_err;
  logic [9:0] s_data;
  logic [7:0] m_data;
  int tests = 0, fails = 0;
`ifdef HGCAL_PACK_STATS_EN
  logic [31:0] stat_frames, stat_errs;
`endif
  hgcal_input_packer #(.IN_WIDTH(10), .NUM_INPUTS(4), .THR1(64), .THR2(128), .THR3(256)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
`ifdef HGCAL_PACK_STATS_EN
    , .stat_frames(stat_frames), .stat_errs(stat_errs)
`endif
  );
  typedef struct {
    int         n;
    logic [9:0] s [6];
    logic [7:0] d;
    logic       e;
  } vec_t;
  vec_t vec [6];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_frame(input int k);
    for (int i = 0; i < vec[k].n; i++) begin
      s_valid = 1'b1;
      s_data  = vec[k].s[i];
      s_last  = i == vec[k].n - 1;
      check($sformatf("v%0d s_ready[%0d]", k, i), 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d m_valid[%0d]", k, i), 32'(m_valid), 32'(i == vec[k].n - 1));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check($sformatf("v%0d m_data", k), 32'(m_data), 32'(vec[k].d));
    check($sformatf("v%0d m_err", k), 32'(m_err), 32'(vec[k].e));
  endtask
  initial begin
    vec[0] = '{4, '{10'd10, 10'd100, 10'd200, 10'd300, 10'd0, 10'd0}, 8'b11100100, 1'b0};
    vec[1] = '{4, '{10'd63, 10'd64, 10'd255, 10'd256, 10'd0, 10'd0}, 8'b11100100, 1'b0};
    vec[2] = '{2, '{10'd300, 10'd300, 10'd0, 10'd0, 10'd0, 10'd0}, 8'b00001111, 1'b1};
    vec[3] = '{6, '{10'd300, 10'd300, 10'd300, 10'd300, 10'd300, 10'd300}, 8'hFF, 1'b1};
    vec[4] = '{1, '{10'd128, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, 8'b00000010, 1'b1};
    vec[5] = '{4, '{10'd0, 10'd1023, 10'd127, 10'd64, 10'd0, 10'd0}, 8'b01011100, 1'b0};
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_data", 32'(m_data), 32'd0);
    check("rst m_err", 32'(m_err), 32'd0);
    check("rst s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst s_ready", 32'(s_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      run_frame(k);
      @(posedge clk);
      #1;
      check($sformatf("v%0d handshake m_valid", k), 32'(m_valid), 32'd0);
      check($sformatf("v%0d handshake s_ready", k), 32'(s_ready), 32'd1);
    end
`ifdef HGCAL_PACK_STATS_EN
    check("stat_frames table", stat_frames, 32'd6);
    check("stat_errs table", stat_errs, 32'd3);
`endif
    m_ready = 1'b0;
    run_frame(0);
    s_valid = 1'b1;
    s_data = 10'd300;
    s_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp m_valid[%0d]", c), 32'(m_valid), 32'd1);
      check($sformatf("bp m_data[%0d]", c), 32'(m_data), 32'hE4);
      check($sformatf("bp s_ready[%0d]", c), 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release m_valid", 32'(m_valid), 32'd0);
    run_frame(1);
    @(posedge clk);
    #1;
    check("bp next handshake", 32'(m_valid), 32'd0);
    s_valid = 1'b1;
    s_data = 10'd300;
    s_last = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid-frame rst m_valid", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    check("mid-frame rst idle m_valid", 32'(m_valid), 32'd0);
    run_frame(0);
    @(posedge clk);
    #1;
    check("after rst handshake", 32'(m_valid), 32'd0);
`ifdef HGCAL_PACK_STATS_EN
    check("stat_frames after rst", stat_frames, 32'd1);
    check("stat_errs after rst", stat_errs, 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
